// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - round-robin arbiter sharing one Data Memory port among accelerator control units
module acc_mem_arbiter #(
   parameter int NUM_ACC        = 4,
   parameter int ADDR_W         = 16,
   parameter int RD_DATA_W      = 512,
   parameter int WR_DATA_W      = 32,
   parameter int MEM_RD_LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_ACC-1:0]            acc_read_en,
   input  logic [NUM_ACC*ADDR_W-1:0]     acc_read_addr,
   input  logic [NUM_ACC-1:0]            acc_write_en,
   input  logic [NUM_ACC*ADDR_W-1:0]     acc_write_addr,
   input  logic [NUM_ACC*WR_DATA_W-1:0]  acc_write_data,
   output logic [RD_DATA_W-1:0]          acc_read_data,
   output logic [NUM_ACC-1:0]            acc_read_data_valid,
   output logic [NUM_ACC-1:0]            acc_write_done,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [WR_DATA_W-1:0]          mem_wdata,
   input  logic [RD_DATA_W-1:0]          mem_rdata,
   output logic                          busy,
   output logic [$clog2(NUM_ACC)-1:0]    grant_idx
);

   localparam int IDX_W     = $clog2(NUM_ACC);
   localparam int CNT_W     = $clog2(MEM_RD_LATENCY + 1);
   localparam int WAIT_LAST = (MEM_RD_LATENCY > 1) ? MEM_RD_LATENCY - 2 : 0;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CAPT  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]           state;
   logic [IDX_W-1:0]     last_grant;
   logic                 op_wr;
   logic [ADDR_W-1:0]    addr_q;
   logic [WR_DATA_W-1:0] wdata_q;
   logic [RD_DATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]     cnt;

   logic [NUM_ACC-1:0]   pend;
   logic [IDX_W-1:0]     pick;
   logic                 any_pend;
   int                   cand;
   int                   pick_i;
   logic [NUM_ACC-1:0]   resp_mask;

   assign pend = acc_read_en | acc_write_en;

   // Walk offsets from farthest to nearest so the nearest pending requester after last_grant wins.
   always_comb begin
      pick     = last_grant;
      any_pend = 1'b0;
      cand     = 0;
      for (int k = NUM_ACC; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % NUM_ACC;
         if (pend[cand]) begin
            pick     = IDX_W'(cand);
            any_pend = 1'b1;
         end
      end
   end

   assign pick_i = int'(pick);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= IDX_W'(NUM_ACC - 1);
         op_wr      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_pend) begin
                  last_grant <= pick;
                  // Read wins when a requester asks for both; its write is picked up on a later grant.
                  op_wr      <= ~acc_read_en[pick_i];
                  addr_q     <= acc_read_en[pick_i] ? acc_read_addr[pick_i*ADDR_W +: ADDR_W]
                                                    : acc_write_addr[pick_i*ADDR_W +: ADDR_W];
                  wdata_q    <= acc_write_data[pick_i*WR_DATA_W +: WR_DATA_W];
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt <= '0;
               if (op_wr)
                  state <= S_RESP;
               else if (MEM_RD_LATENCY > 1)
                  state <= S_WAIT;
               else
                  state <= S_CAPT;
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WAIT_LAST))
                  state <= S_CAPT;
            end
            S_CAPT: begin
               rdata_q <= mem_rdata;
               state   <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign resp_mask           = NUM_ACC'(1) << last_grant;
   assign acc_read_data_valid = (state == S_RESP && !op_wr) ? resp_mask : '0;
   assign acc_write_done      = (state == S_RESP &&  op_wr) ? resp_mask : '0;
   assign acc_read_data       = rdata_q;

   assign mem_en    = (state == S_ISSUE);
   assign mem_we    = mem_en & op_wr;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != S_IDLE);
   assign grant_idx = last_grant;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - directed self-checking bench for acc_mem_arbiter
module tb_acc_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int RW = 512;
   localparam int WW = 32;
   localparam int L  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    rd_en, wr_en;
   logic [N*AW-1:0] rd_addr, wr_addr;
   logic [N*WW-1:0] wr_data;
   logic [RW-1:0]   acc_read_data;
   logic [N-1:0]    valid, done;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [WW-1:0]   mem_wdata;
   logic [RW-1:0]   mem_rdata;
   logic            busy;
   logic [1:0]      grant_idx;

   logic [L-1:0]    rd_pipe = '0;
   logic [RW-1:0]   rd_val;

   int vec = 0;
   int bad = 0;

   int log_idx[$];
   int log_we[$];
   int log_cyc[$];
   int iss_addr[$];
   int iss_we[$];

   always #5 clk = ~clk;

   acc_mem_arbiter #(
      .NUM_ACC(N), .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW), .MEM_RD_LATENCY(L)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .acc_read_en(rd_en), .acc_read_addr(rd_addr),
      .acc_write_en(wr_en), .acc_write_addr(wr_addr), .acc_write_data(wr_data),
      .acc_read_data(acc_read_data), .acc_read_data_valid(valid), .acc_write_done(done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .grant_idx(grant_idx)
   );

   // Memory returns rd_val only in the cycle exactly L cycles after a read issue.
   always @(posedge clk) rd_pipe <= {rd_pipe[L-2:0], mem_en & ~mem_we};
   assign mem_rdata = rd_pipe[L-1] ? rd_val : '0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int max_cycles);
      logic [N-1:0] resp;
      log_idx.delete(); log_we.delete(); log_cyc.delete();
      iss_addr.delete(); iss_we.delete();
      for (int c = 0; c < max_cycles; c++) begin
         step();
         if (mem_en) begin
            iss_addr.push_back(int'(mem_addr));
            iss_we.push_back(int'(mem_we));
         end
         resp = valid | done;
         check("resp_onehot", 512'($onehot0(resp)), 512'd1);
         for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
               log_idx.push_back(i); log_we.push_back(0); log_cyc.push_back(c);
               check("rd_data", acc_read_data, rd_val);
               rd_en[i] = 1'b0;
            end
            if (done[i]) begin
               log_idx.push_back(i); log_we.push_back(1); log_cyc.push_back(c);
               wr_en[i] = 1'b0;
            end
         end
         if (rd_en == '0 && wr_en == '0 && !busy) return;
      end
      check("serve_drained", 512'({rd_en, wr_en}), 512'd0);
   endtask

   task automatic expect_resp(input int k, input int idx, input int we, input int cyc);
      if (k < log_idx.size()) begin
         check($sformatf("resp%0d_idx", k), 512'(log_idx[k]), 512'(idx));
         check($sformatf("resp%0d_we", k), 512'(log_we[k]), 512'(we));
         check($sformatf("resp%0d_cyc", k), 512'(log_cyc[k]), 512'(cyc));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      rd_val = {128{4'hA}} ^ {128{4'hF}} ^ {128{4'hF}};
      rd_val = {64{8'hA5}};
      step(); step(); step();

      check("rst_busy", 512'(busy), 512'd0);
      check("rst_grant", 512'(grant_idx), 512'd3);
      check("rst_mem_en", 512'(mem_en), 512'd0);
      check("rst_mem_we", 512'(mem_we), 512'd0);
      check("rst_mem_addr", 512'(mem_addr), 512'd0);
      check("rst_mem_wdata", 512'(mem_wdata), 512'd0);
      check("rst_rdata", acc_read_data, 512'd0);
      check("rst_pulses", 512'({valid, done}), 512'd0);
      rst_n = 1'b1;
      step();

      // single read, requester 2
      rd_en[2] = 1'b1; rd_addr[2*AW +: AW] = 16'h1000;
      step();
      check("rd_issue_en", 512'(mem_en), 512'd1);
      check("rd_issue_we", 512'(mem_we), 512'd0);
      check("rd_issue_addr", 512'(mem_addr), 512'h1000);
      check("rd_grant", 512'(grant_idx), 512'd2);
      step();
      check("rd_t2_en", 512'(mem_en), 512'd0);
      check("rd_t2_valid", 512'(valid), 512'd0);
      step();
      check("rd_t3_valid", 512'(valid), 512'd0);
      step();
      check("rd_t4_valid", 512'(valid), 512'b0100);
      check("rd_t4_data", acc_read_data, {64{8'hA5}});
      rd_en[2] = 1'b0;
      step();
      check("rd_t5_valid", 512'(valid), 512'd0);
      check("rd_t5_busy", 512'(busy), 512'd0);
      check("rd_hold_data", acc_read_data, {64{8'hA5}});

      // single write, requester 1
      wr_en[1] = 1'b1; wr_addr[1*AW +: AW] = 16'h5000; wr_data[1*WW +: WW] = 32'h0000_0005;
      step();
      check("wr_issue_en", 512'(mem_en), 512'd1);
      check("wr_issue_we", 512'(mem_we), 512'd1);
      check("wr_issue_addr", 512'(mem_addr), 512'h5000);
      check("wr_issue_data", 512'(mem_wdata), 512'd5);
      check("wr_t1_done", 512'(done), 512'd0);
      step();
      check("wr_t2_done", 512'(done), 512'b0010);
      wr_en[1] = 1'b0;
      step();
      check("wr_t3_done", 512'(done), 512'd0);
      check("wr_t3_busy", 512'(busy), 512'd0);

      // fairness from a fresh pointer: four continuous writers
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         wr_addr[i*AW +: AW] = AW'(16'h6000 + i);
         wr_data[i*WW +: WW] = WW'(32'h100 + i);
      end
      wr_en = 4'b1111;
      serve(40);
      check("fair_count", 512'(log_idx.size()), 512'd4);
      for (int k = 0; k < 4; k++) expect_resp(k, k, 1, 1 + 3*k);
      check("fair_issues", 512'(iss_addr.size()), 512'd4);
      for (int k = 0; k < 4 && k < iss_addr.size(); k++)
         check($sformatf("fair_addr%0d", k), 512'(iss_addr[k]), 512'(16'h6000 + k));

      // wrap: after requester 3, both 0 and 3 pending
      wr_en = 4'b1001;
      serve(40);
      check("wrap_count", 512'(log_idx.size()), 512'd2);
      expect_resp(0, 0, 1, 1);
      expect_resp(1, 3, 1, 4);

      // requester 0 asks for read and write at once, requester 1 writes
      rd_val = {16{32'hDEAD_0000 + 32'h1234}};
      rd_en[0] = 1'b1; rd_addr[0*AW +: AW] = 16'h2000;
      wr_en[0] = 1'b1; wr_addr[0*AW +: AW] = 16'h3000;
      wr_en[1] = 1'b1; wr_addr[1*AW +: AW] = 16'h3100;
      serve(40);
      check("rw_count", 512'(log_idx.size()), 512'd3);
      expect_resp(0, 0, 0, 3);
      expect_resp(1, 1, 1, 6);
      expect_resp(2, 0, 1, 9);
      check("rw_issues", 512'(iss_addr.size()), 512'd3);
      if (iss_addr.size() == 3) begin
         check("rw_iss0_addr", 512'(iss_addr[0]), 512'h2000);
         check("rw_iss0_we", 512'(iss_we[0]), 512'd0);
         check("rw_iss1_addr", 512'(iss_addr[1]), 512'h3100);
         check("rw_iss2_addr", 512'(iss_addr[2]), 512'h3000);
         check("rw_iss2_we", 512'(iss_we[2]), 512'd1);
      end

      // reset while waiting on read data
      rd_val = {64{8'h5A}};
      rd_en[0] = 1'b1; rd_addr[0*AW +: AW] = 16'h4000;
      step();
      check("mid_issue_en", 512'(mem_en), 512'd1);
      step();
      check("mid_wait_busy", 512'(busy), 512'd1);
      rst_n = 1'b0;
      step();
      check("mid_rst_busy", 512'(busy), 512'd0);
      check("mid_rst_grant", 512'(grant_idx), 512'd3);
      check("mid_rst_valid", 512'(valid), 512'd0);
      check("mid_rst_mem_en", 512'(mem_en), 512'd0);
      check("mid_rst_rdata", acc_read_data, 512'd0);
      rst_n = 1'b1;
      step();
      check("mid_regrant_en", 512'(mem_en), 512'd1);
      check("mid_regrant_addr", 512'(mem_addr), 512'h4000);
      check("mid_regrant_idx", 512'(grant_idx), 512'd0);
      serve(20);
      check("mid_count", 512'(log_idx.size()), 512'd1);
      expect_resp(0, 0, 0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
